// File: rtl/fir_interp_pkg.sv
// Shared constants, default prototype filter, FSM encoding and output
// round/saturate helper for the interpolate-by-2 polyphase FIR.
package fir_interp_pkg;

  localparam int DATA_W   = 16;
  localparam int COEF_W   = 13;
  localparam int ACC_W    = 32;
  localparam int SHIFT    = 11;
  localparam int TAPS_DEF = 16;

  // Symmetric lowpass prototype, Q1.12; each phase sums to ~2048 (unity after SHIFT).
  localparam logic [TAPS_DEF*COEF_W-1:0] DEF_COEFS = {
    13'(-20),  13'(-45),  13'(60),   13'(120),
    13'(-150), 13'(-260), 13'(620),  13'(1720),
    13'(1720), 13'(620),  13'(-260), 13'(-150),
    13'(120),  13'(60),   13'(-45),  13'(-20)
  };

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  // Round half up, then clamp to the signed DATA_W range.
  function automatic logic signed [DATA_W-1:0] sat_round(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] r;
    logic signed [ACC_W:0] maxv;
    logic signed [ACC_W:0] minv;
    maxv = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    minv = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};
    sum  = {acc[ACC_W-1], acc} + {{(ACC_W+1-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
    r    = sum >>> SHIFT;
    if (r > maxv)      sat_round = maxv[DATA_W-1:0];
    else if (r < minv) sat_round = minv[DATA_W-1:0];
    else               sat_round = r[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/fir_mac_16s_13s.sv
// Signed multiply-accumulate: one combinational product per enabled cycle.
// acc_sum is the accumulator value including the current product.
module fir_mac_16s_13s #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 13,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [COEF_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc_sum
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;

  assign prod    = a * b;
  assign acc_sum = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc_sum;
  end

endmodule

// File: rtl/fir_interp2_polyphase.sv
// Interpolate-by-2 polyphase FIR: each input sample yields a phase-0 then a
// phase-1 output, both computed on one shared multiplier over TAPS/2 cycles.
module fir_interp2_polyphase
  import fir_interp_pkg::*;
#(
  parameter int DATA_W = fir_interp_pkg::DATA_W,
  parameter int COEF_W = fir_interp_pkg::COEF_W,
  parameter int TAPS   = fir_interp_pkg::TAPS_DEF,
  parameter int ACC_W  = fir_interp_pkg::ACC_W,
  parameter int SHIFT  = fir_interp_pkg::SHIFT,
  parameter logic [TAPS*COEF_W-1:0] COEFS = fir_interp_pkg::DEF_COEFS
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
);

  localparam int NPH = TAPS / 2;
  localparam int KW  = $clog2(NPH);

  state_t state, state_nxt;

  logic [NPH-1:0][DATA_W-1:0] x;
  logic [KW-1:0]              k;
  logic                       phase;
  logic                       in_hs, out_hs, last;
  logic signed [COEF_W-1:0]   coef;
  logic signed [ACC_W-1:0]    acc_sum;

  assign in_hs  = s_valid && s_ready;
  assign out_hs = m_valid && m_ready;
  assign last   = (k == KW'(NPH - 1));
  assign coef   = $signed(COEFS[(2*int'(k) + int'(phase))*COEF_W +: COEF_W]);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_hs)  state_nxt = MAC;
      MAC:     if (last)   state_nxt = OUT;
      OUT:     if (out_hs) state_nxt = phase ? IDLE : MAC;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready = (state == IDLE);
    m_valid = (state == OUT);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      x      <= '0;
      k      <= '0;
      phase  <= 1'b0;
      m_data <= '0;
    end else begin
      case (state)
        IDLE: if (in_hs) begin
          x     <= {x[NPH-2:0], s_data};
          k     <= '0;
          phase <= 1'b0;
        end
        MAC: begin
          k <= k + 1'b1;
          // acc_sum already includes the last tap's product on this cycle.
          if (last) m_data <= sat_round(acc_sum);
        end
        OUT: if (out_hs && !phase) begin
          phase <= 1'b1;
          k     <= '0;
        end
        default: ;
      endcase
    end
  end

  fir_mac_16s_13s #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk    (ap_clk),
    .rst_n  (ap_rst_n),
    .clr    (state != MAC),
    .en     (state == MAC),
    .a      ($signed(x[k])),
    .b      (coef),
    .acc_sum(acc_sum)
  );

endmodule
